he_stim_gen: RTL and testbench

- Synthesizable, parametrised stimulus generator for the Hamming encoder datapath.
- Produces bursts of K-bit data words on a valid/ready interface, with selectable data pattern, programmable burst length and inter-word idle gap.
- Sits upstream of the encoder in the SimEnv and in FPGA self-test builds, in place of task-driven data generation.

---
 rtl/he_stim_pkg.sv | 23 ++
 rtl/he_stim_if.sv | 13 +
 rtl/he_stim_pattern.sv | 61 ++++++
 rtl/he_stim_gen.sv | 143 ++++++++++++++
 tb/tb_he_stim_gen.sv | 226 ++++++++++++++++++++++
 5 files changed

// File: rtl/he_stim_pkg.sv
// Shared encodings and defaults for the he_stim_gen stimulus generator.
// The stats build is selected by defining HE_STIM_STATS_EN; see he_stim_gen.sv.
package he_stim_pkg;

   localparam int HE_K_DEFAULT = 4;
   // Taps for x^4+x^3+1, maximal length for a 4-bit left-shifting LFSR.
   localparam logic [HE_K_DEFAULT-1:0] HE_TAPS_DEFAULT = 4'b1100;

   typedef enum logic [1:0] {
      MODE_COUNT = 2'd0,
      MODE_PRBS  = 2'd1,
      MODE_WALK1 = 2'd2,
      MODE_CONST = 2'd3
   } he_mode_e;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_SEND = 2'd1,
      ST_GAP  = 2'd2,
      ST_DONE = 2'd3
   } he_state_e;

endpackage

// File: rtl/he_stim_if.sv
// Data channel from the stimulus generator to the encoder.
// A word transfers on a rising edge where dvld and dready are both high; once dvld
// is raised, dout holds steady and dvld stays high until that transfer happens.
interface he_stim_if #(
   parameter int K = he_stim_pkg::HE_K_DEFAULT
);
   logic [K-1:0] dout;
   logic         dvld;
   logic         dready;

   modport master (output dout, output dvld, input dready);
   modport slave  (input dout, input dvld, output dready);
endinterface

// File: rtl/he_stim_pattern.sv
// Pattern register and next-value logic for COUNT, PRBS, WALK1 and CONST.
// nxt is the value cur takes at the next edge, so the caller can register it directly.
module he_stim_pattern
   import he_stim_pkg::*;
#(
   parameter int            K         = HE_K_DEFAULT,
   parameter logic [K-1:0]  LFSR_TAPS = HE_TAPS_DEFAULT
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         load,
   input  logic         advance,
   input  he_mode_e     mode,
   input  logic [K-1:0] seed,
   output logic [K-1:0] cur,
   output logic [K-1:0] nxt
);

   localparam logic [K-1:0] ONE = {{(K-1){1'b0}}, 1'b1};

   he_mode_e     mode_q;
   logic [K-1:0] first_val;
   logic [K-1:0] step_val;

   always_comb begin
      first_val = seed;
      case (mode)
         // An all-zero LFSR state never leaves zero, so substitute 1.
         MODE_PRBS:  first_val = (seed == '0) ? ONE : seed;
         MODE_WALK1: first_val = ONE;
         default:    first_val = seed;
      endcase
   end

   always_comb begin
      step_val = cur;
      case (mode_q)
         MODE_COUNT: step_val = cur + ONE;
         MODE_PRBS:  step_val = {cur[K-2:0], ^(cur & LFSR_TAPS)};
         MODE_WALK1: step_val = {cur[K-2:0], cur[K-1]};
         default:    step_val = cur;
      endcase
   end

   always_comb begin
      nxt = cur;
      if (load)         nxt = first_val;
      else if (advance) nxt = step_val;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         cur    <= '0;
         mode_q <= MODE_COUNT;
      end else begin
         cur <= nxt;
         if (load) mode_q <= mode;
      end
   end

endmodule

// File: rtl/he_stim_gen.sv
// Burst stimulus generator for the Hamming encoder: patterned K-bit words with gaps.
// Defining HE_STIM_STATS_EN adds saturating word_cnt/stall_cnt outputs.
module he_stim_gen
   import he_stim_pkg::*;
#(
   parameter int           K         = HE_K_DEFAULT,
   parameter int           NW_W      = 16,
   parameter int           GAP_W     = 8,
   parameter logic [K-1:0] LFSR_TAPS = HE_TAPS_DEFAULT
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic [1:0]       mode,
   input  logic [NW_W-1:0]  num_words,
   input  logic [GAP_W-1:0] gap,
   input  logic [K-1:0]     seed,
   he_stim_if.master        dbus,
   output logic             busy,
   output logic             done,
   output he_state_e        dbg_state
`ifdef HE_STIM_STATS_EN
   ,
   output logic [31:0]      word_cnt,
   output logic [31:0]      stall_cnt
`endif
);

   localparam logic [NW_W-1:0]  NW_ONE  = {{(NW_W-1){1'b0}}, 1'b1};
   localparam logic [GAP_W-1:0] GAP_ONE = {{(GAP_W-1){1'b0}}, 1'b1};

   he_state_e        state_q, state_d;
   logic [NW_W-1:0]  remaining_q, remaining_d;
   logic [GAP_W-1:0] gap_len_q, gap_len_d;
   logic [GAP_W-1:0] gap_cnt_q, gap_cnt_d;
   logic [K-1:0]     dout_d;
   logic             dvld_d, busy_d, done_d;
   logic             load, advance, hs;
   logic [K-1:0]     pat_cur, pat_nxt;

   assign hs        = dbus.dvld & dbus.dready;
   assign dbg_state = state_q;

   he_stim_pattern #(
      .K         (K),
      .LFSR_TAPS (LFSR_TAPS)
   ) u_pattern (
      .clk     (clk),
      .rst     (rst),
      .load    (load),
      .advance (advance),
      .mode    (he_mode_e'(mode)),
      .seed    (seed),
      .cur     (pat_cur),
      .nxt     (pat_nxt)
   );

   // State and registered outputs.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= ST_IDLE;
         remaining_q <= '0;
         gap_len_q   <= '0;
         gap_cnt_q   <= '0;
         dbus.dout   <= '0;
         dbus.dvld   <= 1'b0;
         busy        <= 1'b0;
         done        <= 1'b0;
      end else begin
         state_q     <= state_d;
         remaining_q <= remaining_d;
         gap_len_q   <= gap_len_d;
         gap_cnt_q   <= gap_cnt_d;
         dbus.dout   <= dout_d;
         dbus.dvld   <= dvld_d;
         busy        <= busy_d;
         done        <= done_d;
      end
   end

   always_comb begin
      state_d     = state_q;
      remaining_d = remaining_q;
      gap_len_d   = gap_len_q;
      gap_cnt_d   = gap_cnt_q;
      load        = 1'b0;
      advance     = 1'b0;
      case (state_q)
         ST_IDLE: begin
            if (start) begin
               load        = 1'b1;
               remaining_d = num_words;
               gap_len_d   = gap;
               state_d     = (num_words == '0) ? ST_DONE : ST_SEND;
            end
         end
         ST_SEND: begin
            // The pattern steps on every transfer, so a stalled word is never skipped.
            if (hs) begin
               advance     = 1'b1;
               remaining_d = remaining_q - NW_ONE;
               if (remaining_q == NW_ONE) begin
                  state_d = ST_DONE;
               end else if (gap_len_q == '0) begin
                  state_d = ST_SEND;
               end else begin
                  state_d   = ST_GAP;
                  gap_cnt_d = gap_len_q;
               end
            end
         end
         ST_GAP: begin
            if (gap_cnt_q == GAP_ONE) state_d = ST_SEND;
            else                      gap_cnt_d = gap_cnt_q - GAP_ONE;
         end
         default: state_d = ST_IDLE;
      endcase
   end

   // Outputs are computed from the next state so they appear registered with it.
   always_comb begin
      dvld_d = (state_d == ST_SEND);
      dout_d = dvld_d ? pat_nxt : '0;
      busy_d = (state_d == ST_SEND) || (state_d == ST_GAP);
      done_d = (state_d == ST_DONE);
   end

`ifdef HE_STIM_STATS_EN
   always_ff @(posedge clk) begin
      if (rst) begin
         word_cnt  <= '0;
         stall_cnt <= '0;
      end else begin
         if (hs && (word_cnt != '1)) word_cnt <= word_cnt + 32'd1;
         if (dbus.dvld && !dbus.dready && (stall_cnt != '1)) stall_cnt <= stall_cnt + 32'd1;
      end
   end
`else
   logic unused_cur;
   assign unused_cur = ^pat_cur;
`endif

endmodule

// File: tb/tb_he_stim_gen.sv
// Directed bench for he_stim_gen (K=4, default taps); stats checks when HE_STIM_STATS_EN is defined.
module tb_he_stim_gen;
   import he_stim_pkg::*;

   logic        clk = 1'b0;
   logic        rst;
   logic        start;
   logic [1:0]  mode;
   logic [15:0] num_words;
   logic [7:0]  gap;
   logic [3:0]  seed;
   logic        busy;
   logic        done;
   he_state_e   dbg_state;
`ifdef HE_STIM_STATS_EN
   logic [31:0] word_cnt;
   logic [31:0] stall_cnt;
`endif

   int n_cmp  = 0;
   int n_fail = 0;

   logic [3:0] prbs_exp [16] = '{4'h1, 4'h2, 4'h4, 4'h9, 4'h3, 4'h6, 4'hD, 4'hA,
                                 4'h5, 4'hB, 4'h7, 4'hF, 4'hE, 4'hC, 4'h8, 4'h1};
   logic [3:0] walk_exp [5]  = '{4'h1, 4'h2, 4'h4, 4'h8, 4'h1};

   he_stim_if #(.K(4)) dbus ();

   he_stim_gen #(.K(4), .NW_W(16), .GAP_W(8), .LFSR_TAPS(4'b1100)) dut (
      .clk       (clk),
      .rst       (rst),
      .start     (start),
      .mode      (mode),
      .num_words (num_words),
      .gap       (gap),
      .seed      (seed),
      .dbus      (dbus),
      .busy      (busy),
      .done      (done),
      .dbg_state (dbg_state)
`ifdef HE_STIM_STATS_EN
      ,
      .word_cnt  (word_cnt),
      .stall_cnt (stall_cnt)
`endif
   );

   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic check_word(input string tag, input logic [3:0] val);
      check({tag, "_dvld"}, 32'(dbus.dvld), 32'd1);
      check({tag, "_dout"}, 32'(dbus.dout), 32'(val));
   endtask

   task automatic check_quiet(input string tag);
      check({tag, "_dvld"}, 32'(dbus.dvld), 32'd0);
      check({tag, "_dout"}, 32'(dbus.dout), 32'd0);
   endtask

   task automatic start_burst(input logic [1:0] m, input logic [15:0] n,
                              input logic [7:0] g, input logic [3:0] s);
      mode      = m;
      num_words = n;
      gap       = g;
      seed      = s;
      start     = 1'b1;
      tick();
      start     = 1'b0;
   endtask

   initial begin
      rst         = 1'b1;
      start       = 1'b0;
      mode        = 2'd0;
      num_words   = '0;
      gap         = '0;
      seed        = '0;
      dbus.dready = 1'b1;
      tick();
      tick();
      check_quiet("rst");
      check("rst_busy", 32'(busy), 32'd0);
      check("rst_done", 32'(done), 32'd0);
      check("rst_state", 32'(dbg_state), 32'(ST_IDLE));
      rst = 1'b0;
      tick();

      // COUNT wraps E,F,0 back-to-back.
      start_burst(MODE_COUNT, 16'd3, 8'd0, 4'hE);
      check("cnt_busy", 32'(busy), 32'd1);
      check_word("cnt_w0", 4'hE);
      tick();
      check_word("cnt_w1", 4'hF);
      tick();
      check_word("cnt_w2", 4'h0);
      tick();
      check("cnt_done", 32'(done), 32'd1);
      check("cnt_done_busy", 32'(busy), 32'd0);
      check_quiet("cnt_done");
      tick();
      check("cnt_done_pulse", 32'(done), 32'd0);
      check("cnt_idle", 32'(dbg_state), 32'(ST_IDLE));

      // PRBS from seed 0 starts at 1 and repeats after 15 words.
      start_burst(MODE_PRBS, 16'd16, 8'd0, 4'h0);
      for (int i = 0; i < 16; i++) begin
         check_word("prbs", prbs_exp[i]);
         tick();
      end
      check("prbs_done", 32'(done), 32'd1);
      tick();

      // WALK1 with a 2-cycle gap between words, none after the last.
      start_burst(MODE_WALK1, 16'd5, 8'd2, 4'h5);
      for (int i = 0; i < 5; i++) begin
         check_word("walk", walk_exp[i]);
         check("walk_busy", 32'(busy), 32'd1);
         tick();
         if (i < 4) begin
            for (int j = 0; j < 2; j++) begin
               check_quiet("walk_gap");
               check("walk_gap_busy", 32'(busy), 32'd1);
               tick();
            end
         end
      end
      check("walk_done", 32'(done), 32'd1);
      check_quiet("walk_done");
      tick();

      // Backpressure on word 1 holds the value; fresh reset so the stats start at 0.
      rst = 1'b1;
      tick();
      rst = 1'b0;
      tick();
      start_burst(MODE_COUNT, 16'd4, 8'd0, 4'h0);
      check_word("bp_w0", 4'h0);
      tick();
      dbus.dready = 1'b0;
      for (int i = 0; i < 3; i++) begin
         check_word("bp_hold", 4'h1);
         tick();
      end
      dbus.dready = 1'b1;
      check_word("bp_w1", 4'h1);
      tick();
      check_word("bp_w2", 4'h2);
      tick();
      check_word("bp_w3", 4'h3);
      tick();
      check("bp_done", 32'(done), 32'd1);
`ifdef HE_STIM_STATS_EN
      check("stats_word_cnt", word_cnt, 32'd4);
      check("stats_stall_cnt", stall_cnt, 32'd3);
`endif
      tick();

      // Zero-length burst: done one cycle after start, no data.
      start_burst(MODE_COUNT, 16'd0, 8'd0, 4'h7);
      check("zero_done", 32'(done), 32'd1);
      check("zero_busy", 32'(busy), 32'd0);
      check_quiet("zero");
      tick();
      check("zero_done_pulse", 32'(done), 32'd0);
      check_quiet("zero_after");

      // start during GAP is ignored.
      start_burst(MODE_COUNT, 16'd2, 8'd1, 4'h3);
      check_word("ign_w0", 4'h3);
      start     = 1'b1;
      seed      = 4'h9;
      num_words = 16'd7;
      tick();
      check("ign_gap_state", 32'(dbg_state), 32'(ST_GAP));
      check_quiet("ign_gap");
      start = 1'b0;
      tick();
      check_word("ign_w1", 4'h4);
      tick();
      check("ign_done", 32'(done), 32'd1);
      tick();
      check("ign_idle", 32'(dbg_state), 32'(ST_IDLE));
      tick();
      check_quiet("ign_no_restart");
      check("ign_no_restart_busy", 32'(busy), 32'd0);

      // Reset during word 2 of 5 aborts without a done pulse.
      start_burst(MODE_COUNT, 16'd5, 8'd0, 4'h6);
      check_word("abort_w0", 4'h6);
      tick();
      check_word("abort_w1", 4'h7);
      rst = 1'b1;
      tick();
      check_quiet("abort_rst");
      check("abort_busy", 32'(busy), 32'd0);
      check("abort_done", 32'(done), 32'd0);
      rst = 1'b0;
      tick();
      check("abort_no_done", 32'(done), 32'd0);
      check("abort_state", 32'(dbg_state), 32'(ST_IDLE));
      start_burst(MODE_COUNT, 16'd2, 8'd0, 4'h6);
      check_word("fresh_w0", 4'h6);
      tick();
      check_word("fresh_w1", 4'h7);
      tick();
      check("fresh_done", 32'(done), 32'd1);
      tick();

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule
